booth_r8_os_pe: RTL and testbench

Parametrised radix-8 Booth output-stationary processing element for the 2-D systolic MAC arrays, successor to the fixed 32-bit tile PE.

- Consumes pre-encoded multiplier digits arriving from the row edge, and the multiplicand plus its pre-computed triple arriving from the column edge.
- Forwards both operand streams one register stage onward.
- Accumulates products under explicit first/last framing and drains finished results down a column shift chain.
- Adds what the old PE lacked: valid framing, per-operation accumulator clear, configurable widths, signed mode, overflow detection and in-array result draining.

---
 rtl/booth_r8_pkg.sv | 21 ++
 rtl/booth_r8_pp_gen.sv | 44 ++++
 rtl/booth_r8_os_pe.sv | 139 +++++++++++++
 tb/tb_booth_r8_os_pe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_r8_pkg.sv
// Shared types and helpers for the radix-8 Booth output-stationary PE.
package booth_r8_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_ACC_W = 2 * DEF_WIDTH;

  // One pre-encoded radix-8 Booth digit: magnitude one-hot plus negate.
  typedef struct packed {
    logic s;
    logic d;
    logic t;
    logic q;
    logic n;
  } booth_digit_t;

  // Digit count. Unsigned operands need one extra zero bit above the MSB.
  function automatic int unsigned g_of(input int unsigned width, input int unsigned signed_mode);
    return (signed_mode != 0) ? (width + 2) / 3 : (width + 3) / 3;
  endfunction

endpackage

// File: rtl/booth_r8_pp_gen.sv
// Single radix-8 Booth digit: selects y/2y/3y/4y, optionally inverts, and
// places it at weight 8^K. The +1 of a negation is returned as neg_c.
module booth_r8_pp_gen
  import booth_r8_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned K      = 0
) (
  input  logic [WIDTH-1:0]   y,
  input  logic [WIDTH+1:0]   ty,
  input  booth_digit_t       dig,
  output logic [ACC_W-1:0]   pp_c,
  output logic               neg_c
);

  localparam int unsigned SH = 3 * K;

  logic             y_sx;
  logic             ty_sx;
  logic [ACC_W-1:0] y_e;
  logic [ACC_W-1:0] ty_e;
  logic [ACC_W-1:0] mag;

  assign y_sx  = (SIGNED != 0) & y[WIDTH-1];
  assign ty_sx = (SIGNED != 0) & ty[WIDTH+1];
  assign y_e   = {{(ACC_W - WIDTH){y_sx}}, y};
  assign ty_e  = {{(ACC_W - WIDTH - 2){ty_sx}}, ty};

  // Magnitude select from the one-hot digit flags; zero digit gives 0.
  always_comb begin
    mag = '0;
    if (dig.s)      mag = y_e;
    else if (dig.d) mag = y_e << 1;
    else if (dig.t) mag = ty_e;
    else if (dig.q) mag = y_e << 2;
  end

  // Invert before shifting so the matching +1 lands exactly at 8^K.
  assign pp_c  = (dig.n ? ~mag : mag) << SH;
  assign neg_c = dig.n;

endmodule

// File: rtl/booth_r8_os_pe.sv
// Radix-8 Booth output-stationary MAC PE: forwards operands, accumulates
// framed dot products, captures results and shifts them down a drain chain.
module booth_r8_os_pe
  import booth_r8_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned ACC_W  = 2 * WIDTH,
  parameter int unsigned SIGNED = 0,
  localparam int unsigned G     = g_of(WIDTH, SIGNED)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_vld,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [G-1:0]     s,
  input  logic [G-1:0]     d,
  input  logic [G-1:0]     t,
  input  logic [G-1:0]     q,
  input  logic [G-1:0]     n,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH+1:0] ty,
  output logic             vld_out,
  output logic             first_out,
  output logic             last_out,
  output logic [G-1:0]     s_out,
  output logic [G-1:0]     d_out,
  output logic [G-1:0]     t_out,
  output logic [G-1:0]     q_out,
  output logic [G-1:0]     n_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH+1:0] ty_out,
  input  logic             drain,
  input  logic [ACC_W-1:0] res_in,
  input  logic             res_vld_in,
  output logic [ACC_W-1:0] res_out,
  output logic             res_vld,
  output logic             ovf,
  output logic             overrun
);

  booth_digit_t     dig [G];
  logic [ACC_W-1:0] pp_c [G];
  logic [G-1:0]     neg_c;
  logic [ACC_W-1:0] prod_c;
  logic [ACC_W:0]   sum_c;
  logic [ACC_W-1:0] acc_next_c;
  logic             add_ovf_c;
  logic             ovf_next_c;
  logic [ACC_W-1:0] acc;

  for (genvar k = 0; k < G; k++) begin : g_pp
    assign dig[k] = {s[k], d[k], t[k], q[k], n[k]};

    booth_r8_pp_gen #(
      .WIDTH (WIDTH),
      .ACC_W (ACC_W),
      .SIGNED(SIGNED),
      .K     (k)
    ) u_pp (
      .y    (y),
      .ty   (ty),
      .dig  (dig[k]),
      .pp_c (pp_c[k]),
      .neg_c(neg_c[k])
    );
  end

  // Partial-product sum including the negate carries at 8^k.
  always_comb begin
    prod_c = '0;
    for (int k = 0; k < int'(G); k++) begin
      prod_c = prod_c + pp_c[k] + (ACC_W'(neg_c[k]) << (3 * k));
    end
  end

  // Accumulator add, overflow detect and first-term restart.
  always_comb begin
    sum_c      = {1'b0, acc} + {1'b0, prod_c};
    add_ovf_c  = (SIGNED != 0)
               ? ((acc[ACC_W-1] == prod_c[ACC_W-1]) && (sum_c[ACC_W-1] != acc[ACC_W-1]))
               : sum_c[ACC_W];
    acc_next_c = in_first ? prod_c : sum_c[ACC_W-1:0];
    ovf_next_c = in_first ? 1'b0 : (ovf | add_ovf_c);
  end

  // Unconditional one-stage forwarding of operands and framing.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_out   <= 1'b0;
      first_out <= 1'b0;
      last_out  <= 1'b0;
      s_out     <= '0;
      d_out     <= '0;
      t_out     <= '0;
      q_out     <= '0;
      n_out     <= '0;
      y_out     <= '0;
      ty_out    <= '0;
    end else begin
      vld_out   <= in_vld;
      first_out <= in_first;
      last_out  <= in_last;
      s_out     <= s;
      d_out     <= d;
      t_out     <= t;
      q_out     <= q;
      n_out     <= n;
      y_out     <= y;
      ty_out    <= ty;
    end
  end

  // Accumulator, result capture / drain shift and sticky flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc     <= '0;
      ovf     <= 1'b0;
      res_out <= '0;
      res_vld <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (in_vld) begin
        acc <= acc_next_c;
        ovf <= ovf_next_c;
      end
      if (drain) begin
        res_out <= res_in;
        res_vld <= res_vld_in;
        if (in_vld && in_last) overrun <= 1'b1;
      end else if (in_vld && in_last) begin
        res_out <= acc_next_c;
        res_vld <= 1'b1;
        if (res_vld) overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_booth_r8_os_pe.sv
// Bench for booth_r8_os_pe: one unsigned 32-bit PE and a 3-PE signed column.
module tb_booth_r8_os_pe;

  localparam int W = 32, AW = 64, GU = 11;
  localparam int CW = 16, CAW = 32, CG = 6, NC = 3;

  logic CLK, RST;

  // Unsigned PE signals
  logic           in_vld, in_first, in_last;
  logic [GU-1:0]  s, d, t, q, n;
  logic [W-1:0]   y;
  logic [W+1:0]   ty;
  logic           vld_out, first_out, last_out;
  logic [GU-1:0]  s_out, d_out, t_out, q_out, n_out;
  logic [W-1:0]   y_out;
  logic [W+1:0]   ty_out;
  logic           drain;
  logic [AW-1:0]  res_in;
  logic           res_vld_in;
  logic [AW-1:0]  res_out;
  logic           res_vld, ovf, overrun;

  // Signed column signals
  logic           cvld, cfirst, clast, cdrain;
  logic [CG-1:0]  cs [NC], cd [NC], ct [NC], cq [NC], cn [NC];
  logic [CW-1:0]  cy [NC];
  logic [CW+1:0]  cty [NC];
  logic           cvo [NC], cfo [NC], clo [NC];
  logic [CG-1:0]  cso [NC], cdo [NC], cto [NC], cqo [NC], cno [NC];
  logic [CW-1:0]  cyo [NC];
  logic [CW+1:0]  ctyo [NC];
  logic [CAW-1:0] cin [NC], cres [NC];
  logic           cvin [NC], cvres [NC], covf [NC], covr [NC];

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q [$];
  logic [31:0] col_q [$];
  logic [63:0] macc;
  bit          movf, movr, mrv;

  typedef struct {
    logic [31:0] x;
    logic [31:0] yv;
    bit          first;
    bit          last;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [$];

  booth_r8_os_pe #(.WIDTH(W), .ACC_W(AW), .SIGNED(0)) u_dut (
    .CLK(CLK), .RST(RST), .in_vld(in_vld), .in_first(in_first), .in_last(in_last),
    .s(s), .d(d), .t(t), .q(q), .n(n), .y(y), .ty(ty),
    .vld_out(vld_out), .first_out(first_out), .last_out(last_out),
    .s_out(s_out), .d_out(d_out), .t_out(t_out), .q_out(q_out), .n_out(n_out),
    .y_out(y_out), .ty_out(ty_out), .drain(drain), .res_in(res_in),
    .res_vld_in(res_vld_in), .res_out(res_out), .res_vld(res_vld),
    .ovf(ovf), .overrun(overrun)
  );

  for (genvar i = 0; i < NC; i++) begin : g_col
    assign cin[i]  = (i == 0) ? 32'h0 : cres[(i == 0) ? 0 : i - 1];
    assign cvin[i] = (i == 0) ? 1'b0 : cvres[(i == 0) ? 0 : i - 1];

    booth_r8_os_pe #(.WIDTH(CW), .ACC_W(CAW), .SIGNED(1)) u_pe (
      .CLK(CLK), .RST(RST), .in_vld(cvld), .in_first(cfirst), .in_last(clast),
      .s(cs[i]), .d(cd[i]), .t(ct[i]), .q(cq[i]), .n(cn[i]), .y(cy[i]), .ty(cty[i]),
      .vld_out(cvo[i]), .first_out(cfo[i]), .last_out(clo[i]),
      .s_out(cso[i]), .d_out(cdo[i]), .t_out(cto[i]), .q_out(cqo[i]), .n_out(cno[i]),
      .y_out(cyo[i]), .ty_out(ctyo[i]), .drain(cdrain), .res_in(cin[i]),
      .res_vld_in(cvin[i]), .res_out(cres[i]), .res_vld(cvres[i]),
      .ovf(covf[i]), .overrun(covr[i])
    );
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int xb(input logic [63:0] x, input int w, input bit sgn, input int p);
    if (p < 0) return 0;
    if (p < w) return int'(x[p]);
    return sgn ? int'(x[w-1]) : 0;
  endfunction

  // Radix-8 Booth edge encoder: digit_k = -4*x[3k+2] + 2*x[3k+1] + x[3k] + x[3k-1]
  task automatic enc(input logic [63:0] x, input int w, input bit sgn, input int g,
                     output logic [15:0] es, output logic [15:0] ed, output logic [15:0] et,
                     output logic [15:0] eq, output logic [15:0] en);
    es = '0; ed = '0; et = '0; eq = '0; en = '0;
    for (int k = 0; k < g; k++) begin
      int v, m;
      v = -4 * xb(x, w, sgn, 3*k+2) + 2 * xb(x, w, sgn, 3*k+1)
          + xb(x, w, sgn, 3*k) + xb(x, w, sgn, 3*k-1);
      m = (v < 0) ? -v : v;
      en[k] = (v < 0);
      es[k] = (m == 1);
      ed[k] = (m == 2);
      et[k] = (m == 3);
      eq[k] = (m == 4);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drive one term into the unsigned PE, update the model, check one cycle later.
  task automatic term(input logic [31:0] x, input logic [31:0] yy, input bit f, input bit l,
                      input logic [63:0] ex);
    logic [15:0] es, ed, et, eq, en;
    logic [64:0] sum;
    logic [63:0] p, e;
    enc({32'h0, x}, W, 1'b0, GU, es, ed, et, eq, en);
    in_vld = 1'b1; in_first = f; in_last = l;
    s = es[GU-1:0]; d = ed[GU-1:0]; t = et[GU-1:0]; q = eq[GU-1:0]; n = en[GU-1:0];
    y = yy;
    ty = 34'(64'(yy) * 64'd3);
    p = 64'(x) * 64'(yy);
    if (f) begin
      macc = p;
      movf = 1'b0;
    end else begin
      sum  = 65'(macc) + 65'(p);
      macc = sum[63:0];
      movf = movf | sum[64];
    end
    if (l) begin
      if (drain) movr = 1'b1;
      else begin
        if (mrv) movr = 1'b1;
        mrv = 1'b1;
        exp_q.push_back(ex);
      end
    end
    step();
    chk("y_out", 64'(y_out), 64'(yy));
    chk("ty_out", 64'(ty_out), 64'(yy) * 64'd3);
    chk("s_out", 64'(s_out), 64'(es[GU-1:0]));
    chk("d_out", 64'(d_out), 64'(ed[GU-1:0]));
    chk("n_out", 64'(n_out), 64'(en[GU-1:0]));
    chk("framing_out", 64'({vld_out, first_out, last_out}), 64'({1'b1, f, l}));
    chk("ovf", 64'(ovf), 64'(movf));
    chk("overrun", 64'(overrun), 64'(movr));
    if (l && !drain) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: got empty queue expected a result");
      end else begin
        e = exp_q.pop_front();
        chk("res_out", res_out, e);
        chk("res_vld", 64'(res_vld), 64'd1);
      end
    end
    if (l && drain) begin
      chk("drain_res_out", res_out, res_in);
      chk("drain_res_vld", 64'(res_vld), 64'(res_vld_in));
    end
  endtask

  initial begin
    int   xs [NC];
    int   ys [NC];
    logic [15:0] es, ed, et, eq, en;
    logic [31:0] rx, ry, e32;

    RST = 1'b0;
    in_vld = 0; in_first = 0; in_last = 0;
    s = '0; d = '0; t = '0; q = '0; n = '0; y = '0; ty = '0;
    drain = 0; res_in = '0; res_vld_in = 0;
    cvld = 0; cfirst = 0; clast = 0; cdrain = 0;
    for (int i = 0; i < NC; i++) begin
      cs[i] = '0; cd[i] = '0; ct[i] = '0; cq[i] = '0; cn[i] = '0; cy[i] = '0; cty[i] = '0;
    end
    macc = '0; movf = 0; movr = 0; mrv = 0;

    step(); step();
    chk("rst_res_out", res_out, 64'd0);
    chk("rst_res_vld", 64'(res_vld), 64'd0);
    chk("rst_flags", 64'({ovf, overrun}), 64'd0);
    chk("rst_fwd", 64'({vld_out, y_out}), 64'd0);
    chk("rst_col_res", 64'(cres[NC-1]), 64'd0);
    RST = 1'b1;
    step();

    // Vector table: single terms, dot products, wrap/overflow and edge operands.
    tbl.push_back('{32'd3, 32'd5, 1'b1, 1'b1, 64'd15});
    tbl.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'hFFFFFFFE00000001});
    tbl.push_back('{32'd1, 32'd5, 1'b1, 1'b0, 64'd0});
    tbl.push_back('{32'd2, 32'd6, 1'b0, 1'b0, 64'd0});
    tbl.push_back('{32'd3, 32'd7, 1'b0, 1'b0, 64'd0});
    tbl.push_back('{32'd4, 32'd8, 1'b0, 1'b1, 64'd70});
    tbl.push_back('{32'd2, 32'd2, 1'b1, 1'b1, 64'd4});
    for (int i = 0; i < 10; i++)
      tbl.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, (i == 0), (i == 9),
                      (i == 9) ? 64'hFFFFFFEC0000000A : 64'd0});
    tbl.push_back('{32'd3, 32'd3, 1'b1, 1'b1, 64'd9});
    tbl.push_back('{32'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 64'd0});
    tbl.push_back('{32'hFFFFFFFF, 32'd1, 1'b1, 1'b1, 64'h00000000FFFFFFFF});
    tbl.push_back('{32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000000000000000});
    for (int i = 0; i < 4; i++) begin
      rx = $urandom; ry = $urandom;
      tbl.push_back('{rx, ry, 1'b1, 1'b1, 64'(rx) * 64'(ry)});
    end
    for (int i = 0; i < tbl.size(); i++)
      term(tbl[i].x, tbl[i].yv, tbl[i].first, tbl[i].last, tbl[i].exp);

    // in_last during drain: capture suppressed, overrun set, acc still updated.
    drain = 1'b1; res_in = 64'hDEADBEEF01234567; res_vld_in = 1'b1;
    term(32'd2, 32'd3, 1'b1, 1'b1, 64'd0);
    drain = 1'b0; res_vld_in = 1'b0; res_in = '0;
    term(32'd1, 32'd1, 1'b0, 1'b1, 64'd7);

    // Asynchronous reset in the middle of a product.
    term(32'd5, 32'd5, 1'b1, 1'b0, 64'd0);
    in_vld = 1'b0; in_first = 1'b0; in_last = 1'b0;
    #2 RST = 1'b0;
    #1;
    chk("arst_res_out", res_out, 64'd0);
    chk("arst_flags", 64'({res_vld, ovf, overrun}), 64'd0);
    chk("arst_fwd", 64'({vld_out, y_out}), 64'd0);
    macc = '0; movf = 0; movr = 0; mrv = 0;
    step();
    RST = 1'b1;
    step();
    term(32'd7, 32'd9, 1'b1, 1'b1, 64'd63);

    // Signed column: one single-term product per PE, then drain bottom-first.
    xs = '{-3, 7, -100};
    ys = '{5, -4, -200};
    for (int i = 0; i < NC; i++) begin
      enc({48'h0, 16'(xs[i])}, CW, 1'b1, CG, es, ed, et, eq, en);
      cs[i] = es[CG-1:0]; cd[i] = ed[CG-1:0]; ct[i] = et[CG-1:0];
      cq[i] = eq[CG-1:0]; cn[i] = en[CG-1:0];
      cy[i] = 16'(ys[i]);
      cty[i] = 18'(3 * ys[i]);
    end
    for (int i = NC - 1; i >= 0; i--) col_q.push_back(32'(xs[i] * ys[i]));
    cvld = 1'b1; cfirst = 1'b1; clast = 1'b1;
    step();
    cvld = 1'b0; cfirst = 1'b0; clast = 1'b0;
    chk("col_pe0_res", 64'(cres[0]), 64'h00000000FFFFFFF1);
    chk("col_pe0_ty_out", 64'(ctyo[0]), 64'h000000000000000F);
    e32 = col_q.pop_front();
    chk("col_bottom_res", 64'(cres[NC-1]), 64'(e32));
    chk("col_bottom_vld", 64'(cvres[NC-1]), 64'd1);
    cdrain = 1'b1;
    for (int i = 0; i < NC; i++) begin
      step();
      if (i < NC - 1) begin
        e32 = col_q.pop_front();
        chk("col_drain_res", 64'(cres[NC-1]), 64'(e32));
        chk("col_drain_vld", 64'(cvres[NC-1]), 64'd1);
      end else begin
        chk("col_empty_vld", 64'(cvres[NC-1]), 64'd0);
      end
    end
    cdrain = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
